exu_trap_ctrl: RTL and testbench
================================

// Module: exu_trap_ctrl
// PURPOSE
// - Trap sequencer for the machine-mode CSR file: decides and sequences trap entry (sync exception or interrupt) and mret.
// - Sits beside the CSR file in EXU: reads its MIE/mie/mip/mtvec/mepc views, drives its trap_ena/mret_ena/epc_en/epc_pc
//   strobes plus an mcause write port, flushes the pipeline and redirects fetch to the handler or return address.
// PARAMETERS
// - XLEN     32  data/PC width
// - VEC_EN   1   1: honour mtvec.MODE=01 (vectored interrupts); 0: always direct mode
// PORTS
// - clk            in   1     clock
// - rst            in   1     reset; one clock; reset is synchronous and active-high
// - st_mie         in   1     mstatus.MIE from CSR file
// - irq_en         in   3     {meie,msie,mtie} from mie
// - irq_pend       in   3     {meip,msip,mtip} from mip (level)
// - mtvec          in   XLEN  mtvec CSR value
// - mepc           in   XLEN  mepc CSR value (bit0 already 0)
// - commit_vld     in   1     an instruction is at commit; commit_pc valid
// - commit_pc      in   XLEN  PC of oldest unretired instruction
// - exc_vld        in   1     commit instruction raised a sync exception (qualified by commit_vld)
// - exc_cause      in   4     exception code
// - mret_req       in   1     commit instruction is mret (qualified by commit_vld)
// - flush_req      out  1     request pipeline flush; held until flush_ack
// - flush_ack      in   1     pipeline drained, nothing will retire
// - trap_ena       out  1     1-cycle pulse to CSR file: trap entry (MPIE<=MIE, MIE<=0)
// - mret_ena       out  1     1-cycle pulse to CSR file: mret (MIE<=MPIE, MPIE<=1)
// - epc_en         out  1     1-cycle pulse: write epc_pc to mepc (same cycle as trap_ena)
// - epc_pc         out  XLEN  PC to save
// - mcause_wen     out  1     1-cycle pulse with trap_ena
// - mcause_dat     out  XLEN  {irq_flag, 27'b0, code}
// - redir_vld      out  1     fetch redirect valid; held until redir_rdy
// - redir_pc       out  XLEN  redirect target; stable while redir_vld
// - redir_rdy      in   1     fetch accepts redirect
// - busy           out  1     state != IDLE; commit stage must stall retirement
// BEHAVIOUR
// - Reset: state=IDLE; every output 0; latched cause/pc/target cleared. rst mid-sequence aborts with no CSR pulse.
// - irq_act = irq_pend & irq_en & {3{st_mie}}; priority MEI(11) > MSI(3) > MTI(7).
// - IDLE decision, priority exc_vld > mret_req > irq (exc/mret need commit_vld; irq needs commit_vld for epc):
//   latch kind, code, epc=commit_pc, target; go FLUSH (flush_req=1 next cycle). Nothing else -> stay IDLE.
// - Interrupts are level; arrivals outside IDLE are not queued, re-evaluated on return to IDLE.
// - FLUSH: hold flush_req until flush_ack; flush_ack same cycle as entry counts -> COMMIT next cycle.
// - COMMIT (exactly 1 cycle): trap -> trap_ena, epc_en, mcause_wen = 1; mret -> mret_ena = 1 only. Then REDIR.
// - REDIR: redir_vld=1 with latched redir_pc until redir_rdy; then IDLE. Min latency decision->redir_vld = 3 cycles.
// - Target: trap base = {mtvec[31:2],2'b00}; if VEC_EN && mtvec[1:0]==01 && interrupt -> base + (code<<2), wraps mod 2^XLEN;
//   exceptions always base; mtvec[1:0]>=10 treated as direct. mret target = mepc sampled at decision.
// - mcause_dat: bit31=1 for interrupt, code in [3:0] (exc_cause zero-extended); other bits 0.
// - busy=1 in FLUSH/COMMIT/REDIR; exc_vld/mret_req/irq ignored while busy.
// STRUCTURE
// - Shared package: state encoding (IDLE/FLUSH/COMMIT/REDIR), interrupt codes (MEI=11,MSI=3,MTI=7), mtvec mode consts.
// - One sub-module: exu_irq_prio (combinational 3-way priority pick -> vld + 4-bit code).
// - All state/latch regs use the codebase's synchronous-reset flop cells.
// TESTING
// - Exception: commit_pc=0x100, exc_cause=2, mtvec=0x8000_0000, flush_ack next cycle -> trap_ena/epc_en/mcause_wen
//   pulse once, epc_pc=0x100, mcause_dat=0x2, redir_pc=0x8000_0000.
// - Vectored MTI: st_mie=1, irq_en=3'b111, irq_pend=3'b001, mtvec=0x8000_0001 -> mcause_dat=0x8000_0007, redir_pc=0x8000_001C.
// - Priority: exc_vld and all irq pending same cycle -> exception taken (mcause 0x..0 bit31=0); then MEI on return to IDLE.
// - mret: mepc=0x204, mret_req -> mret_ena single pulse, no trap_ena/epc_en, redir_pc=0x204.
// - Backpressure: flush_ack low 5 cycles, redir_rdy low 3 cycles -> flush_req/redir_vld held, redir_pc stable, one pulse.
// - rst asserted in FLUSH -> next cycle all outputs 0, state IDLE, no CSR strobe ever emitted for that event.

Source files
------------

// File: rtl/exu_trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// State encoding, interrupt cause codes and mtvec mode values.
package exu_trap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_REDIR  = 2'd3
    } trap_state_e;

    localparam logic [3:0] IRQ_MEI = 4'd11;
    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;

    localparam int IRQ_BIT_MEI = 2;
    localparam int IRQ_BIT_MSI = 1;
    localparam int IRQ_BIT_MTI = 0;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/exu_irq_prio.sv
// Fixed-priority pick among active machine interrupts.
// MEI beats MSI beats MTI; code is the mcause interrupt code.
module exu_irq_prio
    import exu_trap_ctrl_pkg::*;
(
    input  logic [2:0] irq_act,
    output logic       irq_vld,
    output logic [3:0] irq_code
);

    // priority chain: highest-ranked active source wins
    always_comb begin
        irq_vld  = |irq_act;
        irq_code = 4'd0;
        if (irq_act[IRQ_BIT_MEI]) begin
            irq_code = IRQ_MEI;
        end else if (irq_act[IRQ_BIT_MSI]) begin
            irq_code = IRQ_MSI;
        end else if (irq_act[IRQ_BIT_MTI]) begin
            irq_code = IRQ_MTI;
        end
    end

endmodule

// File: rtl/exu_trap_ctrl.sv
// Trap entry / mret sequencer beside the machine-mode CSR file.
// Decides at commit, flushes, strobes the CSRs once, redirects fetch.
module exu_trap_ctrl
    import exu_trap_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit VEC_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            st_mie,
    input  logic [2:0]      irq_en,
    input  logic [2:0]      irq_pend,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            commit_vld,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            exc_vld,
    input  logic [3:0]      exc_cause,
    input  logic            mret_req,
    output logic            flush_req,
    input  logic            flush_ack,
    output logic            trap_ena,
    output logic            mret_ena,
    output logic            epc_en,
    output logic [XLEN-1:0] epc_pc,
    output logic            mcause_wen,
    output logic [XLEN-1:0] mcause_dat,
    output logic            redir_vld,
    output logic [XLEN-1:0] redir_pc,
    input  logic            redir_rdy,
    output logic            busy
);

    trap_state_e state;
    logic        is_trap;

    logic [2:0]      irq_act;
    logic            irq_vld;
    logic [3:0]      irq_code;
    logic            take_exc;
    logic            take_mret;
    logic            take_irq;
    logic            vec_mode;
    logic [3:0]      code_nxt;
    logic [XLEN-1:0] cause_nxt;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] tvec_irq;
    logic [XLEN-1:0] trap_tgt;

    assign irq_act = irq_pend & irq_en & {3{st_mie}};

    exu_irq_prio u_prio (
        .irq_act  (irq_act),
        .irq_vld  (irq_vld),
        .irq_code (irq_code)
    );

    // exception outranks mret, mret outranks interrupt
    assign take_exc  = commit_vld & exc_vld;
    assign take_mret = commit_vld & mret_req & ~exc_vld;
    assign take_irq  = commit_vld & irq_vld & ~exc_vld & ~mret_req;

    assign code_nxt  = take_exc ? exc_cause : irq_code;
    assign cause_nxt = {take_irq, {(XLEN-5){1'b0}}, code_nxt};

    // reserved modes (>=10) fall back to direct
    assign vec_mode  = VEC_EN && (mtvec[1:0] == MTVEC_VECTORED);
    assign tvec_base = {mtvec[XLEN-1:2], 2'b00};
    assign tvec_irq  = tvec_base
                     + {{(XLEN-6){1'b0}}, irq_code, 2'b00};
    assign trap_tgt  = (take_irq && vec_mode) ? tvec_irq : tvec_base;

    assign busy = (state != ST_IDLE);

    // sequencer FSM with registered strobes and latched trap context
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            is_trap    <= 1'b0;
            flush_req  <= 1'b0;
            trap_ena   <= 1'b0;
            mret_ena   <= 1'b0;
            epc_en     <= 1'b0;
            mcause_wen <= 1'b0;
            epc_pc     <= '0;
            mcause_dat <= '0;
            redir_vld  <= 1'b0;
            redir_pc   <= '0;
        end else begin
            trap_ena   <= 1'b0;
            mret_ena   <= 1'b0;
            epc_en     <= 1'b0;
            mcause_wen <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (take_exc || take_irq) begin
                        is_trap    <= 1'b1;
                        epc_pc     <= commit_pc;
                        mcause_dat <= cause_nxt;
                        redir_pc   <= trap_tgt;
                        flush_req  <= 1'b1;
                        state      <= ST_FLUSH;
                    end else if (take_mret) begin
                        is_trap   <= 1'b0;
                        redir_pc  <= mepc;
                        flush_req <= 1'b1;
                        state     <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (flush_ack) begin
                        flush_req  <= 1'b0;
                        trap_ena   <= is_trap;
                        epc_en     <= is_trap;
                        mcause_wen <= is_trap;
                        mret_ena   <= ~is_trap;
                        state      <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    redir_vld <= 1'b1;
                    state     <= ST_REDIR;
                end
                ST_REDIR: begin
                    if (redir_rdy) begin
                        redir_vld <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exu_trap_ctrl.sv
// Self-checking bench for exu_trap_ctrl.
// Vector table plus hand sequences; CSR strobes checked via a queue.
module tb_exu_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_mie = 1'b0;
    logic [2:0]  irq_en = '0;
    logic [2:0]  irq_pend = '0;
    logic [31:0] mtvec = '0;
    logic [31:0] mepc = '0;
    logic        commit_vld = 1'b0;
    logic [31:0] commit_pc = '0;
    logic        exc_vld = 1'b0;
    logic [3:0]  exc_cause = '0;
    logic        mret_req = 1'b0;
    logic        flush_req;
    logic        flush_ack = 1'b0;
    logic        trap_ena;
    logic        mret_ena;
    logic        epc_en;
    logic [31:0] epc_pc;
    logic        mcause_wen;
    logic [31:0] mcause_dat;
    logic        redir_vld;
    logic [31:0] redir_pc;
    logic        redir_rdy = 1'b0;
    logic        busy;

    exu_trap_ctrl #(.XLEN(32), .VEC_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .st_mie     (st_mie),
        .irq_en     (irq_en),
        .irq_pend   (irq_pend),
        .mtvec      (mtvec),
        .mepc       (mepc),
        .commit_vld (commit_vld),
        .commit_pc  (commit_pc),
        .exc_vld    (exc_vld),
        .exc_cause  (exc_cause),
        .mret_req   (mret_req),
        .flush_req  (flush_req),
        .flush_ack  (flush_ack),
        .trap_ena   (trap_ena),
        .mret_ena   (mret_ena),
        .epc_en     (epc_en),
        .epc_pc     (epc_pc),
        .mcause_wen (mcause_wen),
        .mcause_dat (mcause_dat),
        .redir_vld  (redir_vld),
        .redir_pc   (redir_pc),
        .redir_rdy  (redir_rdy),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_trap;
        logic [31:0] mcause;
        logic [31:0] epc;
        logic [31:0] redir;
    } exp_t;

    // kind: 0 = no event, 1 = trap, 2 = mret
    typedef struct {
        logic        cv;
        logic        mie;
        logic [2:0]  en;
        logic [2:0]  pend;
        logic [31:0] tvec;
        logic [31:0] epc_in;
        logic [31:0] pc;
        logic        exc;
        logic [3:0]  cause;
        logic        mret;
        int          kind;
        logic [31:0] mcause;
        logic [31:0] epc;
        logic [31:0] redir;
        int          ack_dly;
        int          rdy_dly;
    } vec_t;

    exp_t        q[$];
    logic [31:0] cur_redir = '0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_trap = 0;
    int          n_mret = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                      name, act, req, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // strobe monitor: pops the expected record on each CSR pulse
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (trap_ena || epc_en || mcause_wen)
                check("strobe_align",
                      32'({trap_ena, epc_en, mcause_wen}),
                      32'({3{trap_ena}}));
            if (trap_ena) n_trap++;
            if (mret_ena) n_mret++;
            if (trap_ena || mret_ena) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse",
                          32'({trap_ena, mret_ena}), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("pulse_kind", 32'({trap_ena, mret_ena}),
                          e.is_trap ? 32'd2 : 32'd1);
                    if (e.is_trap) begin
                        check("epc_pc", epc_pc, e.epc);
                        check("mcause_dat", mcause_dat, e.mcause);
                    end
                    cur_redir = e.redir;
                end
            end
            if (redir_vld) check("redir_pc", redir_pc, cur_redir);
        end
    end

    // called #1 after the decision edge; walks one event to IDLE
    task automatic run_event(input int ack_dly, input int rdy_dly);
        int k;
        check("flush_req_rise", 32'(flush_req), 32'd1);
        k = 0;
        while (!flush_req && k < 8) begin
            step();
            k++;
        end
        if (!flush_req) return;
        for (int i = 0; i < ack_dly; i++) begin
            step();
            check("flush_hold", 32'(flush_req), 32'd1);
            check("busy_flush", 32'(busy), 32'd1);
        end
        flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
        check("commit_pulse", 32'(trap_ena | mret_ena), 32'd1);
        check("flush_drop", 32'(flush_req), 32'd0);
        step();
        check("redir_rise", 32'(redir_vld), 32'd1);
        k = 0;
        while (!redir_vld && k < 8) begin
            step();
            k++;
        end
        if (!redir_vld) return;
        for (int i = 0; i < rdy_dly; i++) begin
            step();
            check("redir_hold", 32'(redir_vld), 32'd1);
        end
        redir_rdy = 1'b1;
        step();
        redir_rdy = 1'b0;
        check("idle_after", 32'({busy, redir_vld, flush_req}), 32'd0);
    endtask

    vec_t vt[13];

    initial begin
        exp_t e;
        int   t0;
        int   m0;

        vt[0]  = '{1'b1, 1'b0, 3'd0, 3'd0, 32'h8000_0000, 32'h0,
                   32'h100, 1'b1, 4'd2, 1'b0, 1,
                   32'h0000_0002, 32'h100, 32'h8000_0000, 0, 0};
        vt[1]  = '{1'b1, 1'b1, 3'd7, 3'b001, 32'h8000_0001, 32'h0,
                   32'h200, 1'b0, 4'd0, 1'b0, 1,
                   32'h8000_0007, 32'h200, 32'h8000_001C, 0, 0};
        vt[2]  = '{1'b1, 1'b1, 3'd7, 3'b010, 32'h8000_0001, 32'h0,
                   32'h204, 1'b0, 4'd0, 1'b0, 1,
                   32'h8000_0003, 32'h204, 32'h8000_000C, 1, 1};
        vt[3]  = '{1'b1, 1'b1, 3'd7, 3'b100, 32'h4000_0002, 32'h0,
                   32'h208, 1'b0, 4'd0, 1'b0, 1,
                   32'h8000_000B, 32'h208, 32'h4000_0000, 0, 2};
        vt[4]  = '{1'b1, 1'b0, 3'd0, 3'd0, 32'h8000_0001, 32'h0,
                   32'h20C, 1'b1, 4'd11, 1'b0, 1,
                   32'h0000_000B, 32'h20C, 32'h8000_0000, 2, 0};
        vt[5]  = '{1'b1, 1'b0, 3'd0, 3'd0, 32'h8000_0000, 32'h204,
                   32'h210, 1'b0, 4'd0, 1'b1, 2,
                   32'h0, 32'h0, 32'h0000_0204, 0, 0};
        vt[6]  = '{1'b1, 1'b1, 3'b100, 3'b100, 32'hFFFF_FFFD, 32'h0,
                   32'h214, 1'b0, 4'd0, 1'b0, 1,
                   32'h8000_000B, 32'h214, 32'h0000_0028, 0, 0};
        vt[7]  = '{1'b1, 1'b0, 3'd7, 3'd7, 32'h8000_0001, 32'h0,
                   32'h218, 1'b0, 4'd0, 1'b0, 0,
                   32'h0, 32'h0, 32'h0, 0, 0};
        vt[8]  = '{1'b1, 1'b1, 3'b010, 3'd7, 32'h0000_1000, 32'h0,
                   32'h21C, 1'b0, 4'd0, 1'b0, 1,
                   32'h8000_0003, 32'h21C, 32'h0000_1000, 0, 0};
        vt[9]  = '{1'b1, 1'b0, 3'd0, 3'd0, 32'h8000_0000, 32'h300,
                   32'h220, 1'b1, 4'd5, 1'b1, 1,
                   32'h0000_0005, 32'h220, 32'h8000_0000, 0, 0};
        vt[10] = '{1'b1, 1'b0, 3'd0, 3'd0, 32'h0000_2001, 32'h0,
                   32'h224, 1'b1, 4'd7, 1'b0, 1,
                   32'h0000_0007, 32'h224, 32'h0000_2000, 5, 3};
        vt[11] = '{1'b1, 1'b1, 3'd7, 3'd7, 32'h8000_0001, 32'h400,
                   32'h228, 1'b0, 4'd0, 1'b1, 2,
                   32'h0, 32'h0, 32'h0000_0400, 0, 0};
        vt[12] = '{1'b0, 1'b1, 3'd7, 3'd7, 32'h8000_0001, 32'h0,
                   32'h22C, 1'b1, 4'd3, 1'b1, 0,
                   32'h0, 32'h0, 32'h0, 0, 0};

        rst = 1'b1;
        step();
        step();
        check("rst_outs", 32'({flush_req, trap_ena, mret_ena, epc_en,
                              mcause_wen, redir_vld, busy}), 32'd0);
        check("rst_epc", epc_pc, 32'd0);
        check("rst_mcause", mcause_dat, 32'd0);
        check("rst_redir", redir_pc, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 13; i++) begin
            t0 = n_trap;
            m0 = n_mret;
            st_mie     = vt[i].mie;
            irq_en     = vt[i].en;
            irq_pend   = vt[i].pend;
            mtvec      = vt[i].tvec;
            mepc       = vt[i].epc_in;
            commit_pc  = vt[i].pc;
            exc_vld    = vt[i].exc;
            exc_cause  = vt[i].cause;
            mret_req   = vt[i].mret;
            commit_vld = vt[i].cv;
            if (vt[i].kind != 0) begin
                e.is_trap = (vt[i].kind == 1);
                e.mcause  = vt[i].mcause;
                e.epc     = vt[i].epc;
                e.redir   = vt[i].redir;
                q.push_back(e);
            end
            step();
            commit_vld = 1'b0;
            exc_vld    = 1'b0;
            mret_req   = 1'b0;
            irq_pend   = '0;
            if (vt[i].kind == 0) begin
                for (int k = 0; k < 3; k++) begin
                    check("no_event", 32'({flush_req, busy}), 32'd0);
                    step();
                end
            end else begin
                run_event(vt[i].ack_dly, vt[i].rdy_dly);
            end
            check("trap_cnt", 32'(n_trap - t0),
                  32'(vt[i].kind == 1));
            check("mret_cnt", 32'(n_mret - m0),
                  32'(vt[i].kind == 2));
            check("q_drained", 32'(q.size()), 32'd0);
        end

        // exception beats pending irqs; MEI taken once back in IDLE
        t0 = n_trap;
        st_mie     = 1'b1;
        irq_en     = 3'd7;
        irq_pend   = 3'd7;
        mtvec      = 32'h8000_0001;
        commit_pc  = 32'h300;
        exc_vld    = 1'b1;
        exc_cause  = 4'd0;
        commit_vld = 1'b1;
        q.push_back('{1'b1, 32'h0, 32'h300, 32'h8000_0000});
        q.push_back('{1'b1, 32'h8000_000B, 32'h304, 32'h8000_002C});
        step();
        exc_vld   = 1'b0;
        commit_pc = 32'h304;
        run_event(0, 0);
        step();
        run_event(0, 0);
        commit_vld = 1'b0;
        irq_pend   = '0;
        check("prio_trap_cnt", 32'(n_trap - t0), 32'd2);
        check("prio_q_drained", 32'(q.size()), 32'd0);

        // reset while flushing: no CSR strobe for that event
        t0 = n_trap;
        m0 = n_mret;
        mtvec      = 32'h9000_0000;
        commit_pc  = 32'h500;
        exc_vld    = 1'b1;
        exc_cause  = 4'd4;
        commit_vld = 1'b1;
        step();
        commit_vld = 1'b0;
        exc_vld    = 1'b0;
        check("abort_in_flush", 32'(flush_req), 32'd1);
        rst = 1'b1;
        step();
        check("abort_outs", 32'({flush_req, trap_ena, mret_ena, epc_en,
                                mcause_wen, redir_vld, busy}), 32'd0);
        check("abort_epc", epc_pc, 32'd0);
        check("abort_mcause", mcause_dat, 32'd0);
        check("abort_redir", redir_pc, 32'd0);
        rst = 1'b0;
        flush_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("abort_idle", 32'({flush_req, busy}), 32'd0);
        end
        flush_ack = 1'b0;
        check("abort_no_pulse", 32'((n_trap - t0) + (n_mret - m0)),
              32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
